// File: rtl/wubsuit_midi_pkg.sv
// Shared types and constants for the drum-trigger MIDI transmitter.
// NOTE_MAP gives the General MIDI drum note for each trigger index.
package wubsuit_midi_pkg;

  localparam int IDX_W = 3;
  localparam logic [3:0] NOTE_ON = 4'h9;
  localparam logic [7:0] NOTE_MAP [6] = '{8'd36, 8'd38, 8'd42, 8'd46, 8'd49, 8'd51};

  typedef enum logic [1:0] {
    S_IDLE,
    S_STATUS,
    S_NOTE,
    S_VEL
  } tx_state_t;

  // Index values outside the map are not produced by the arbiter.
  function automatic logic [7:0] note_of(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return NOTE_MAP[0];
      3'd1:    return NOTE_MAP[1];
      3'd2:    return NOTE_MAP[2];
      3'd3:    return NOTE_MAP[3];
      3'd4:    return NOTE_MAP[4];
      3'd5:    return NOTE_MAP[5];
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit.
// done pulses in the last cycle of the stop bit; a start in that cycle chains with no gap.
module midi_uart_tx #(
  parameter int BAUD_DIV = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;
  logic             load;

  assign bit_end = (div_cnt == DIV_W'(BAUD_DIV - 1));
  assign done    = busy && bit_end && (bit_cnt == 4'd9);
  // start is ignored while busy, except in the final stop-bit cycle
  assign load    = start && (!busy || done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      txd     <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      busy    <= 1'b1;
      txd     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (busy) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          txd  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          txd     <= (bit_cnt == 4'd8) ? 1'b1 : shreg[0];
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      shreg <= data;
    else if (busy && bit_end && (bit_cnt < 4'd8))
      shreg <= shreg >> 1;
  end

endmodule

// File: rtl/piezo_midi_tx.sv
// Drum triggers -> synchronise, edge detect, holdoff, queue, MIDI Note On over UART.
// Optional MIDI_RUNNING_STATUS_EN omits the status byte once it has been sent.
module piezo_midi_tx
  import wubsuit_midi_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int BAUD       = 31250,
  parameter int N_TRIG     = 6,
  parameter int HOLDOFF_MS = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int MIDI_CH    = 9,
  parameter int VELOCITY   = 100
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic [N_TRIG-1:0] TRIG,
  output logic              MIDI_TX,
  output logic              BUSY,
  output logic              OVERFLOW
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int MS_DIV   = CLK_HZ / 1000;
  localparam int MS_W     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int HO_W     = $clog2(HOLDOFF_MS + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [7:0] STATUS_BYTE = {NOTE_ON, 4'(MIDI_CH)};
  localparam logic [7:0] VEL_BYTE    = {1'b0, 7'(VELOCITY)};

  logic [N_TRIG-1:0] sync_p1, sync_p2, sync_p3, edge_p3;
  logic [MS_W-1:0]   ms_cnt;
  logic              ms_tick;
  logic [HO_W-1:0]   holdoff [N_TRIG];
  logic [N_TRIG-1:0] in_hold, accept, dropv, pending, grant;
  logic [IDX_W-1:0]  push_idx;
  logic              push, pop;
  logic [IDX_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty;
  tx_state_t         state;
  logic              start_r;
  logic [IDX_W-1:0]  idx_r;
  logic              skip_status;
  logic              uart_start, uart_busy, uart_done;
  logic [7:0]        tx_byte;

  // ---- stage p1..p3: two-flop synchroniser plus registered rising edge
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
      sync_p3 <= '0;
      edge_p3 <= '0;
    end else begin
      sync_p1 <= TRIG;
      sync_p2 <= sync_p1;
      sync_p3 <= sync_p2;
      edge_p3 <= sync_p2 & ~sync_p3;
    end
  end

  assign ms_tick = (ms_cnt == MS_W'(MS_DIV - 1));

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) ms_cnt <= '0;
    else          ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
  end

  // ---- stage: holdoff filter and pending mask
  always_comb begin
    for (int i = 0; i < N_TRIG; i++)
      in_hold[i] = (holdoff[i] != '0);
  end

  assign accept = edge_p3 & ~in_hold & ~pending;
  assign dropv  = edge_p3 & ~in_hold & pending;

  // Scan from the top so the lowest pending index is the one left granted.
  always_comb begin
    grant    = '0;
    push_idx = '0;
    for (int i = N_TRIG - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        push_idx = IDX_W'(i);
      end
    end
  end

  assign push = (|pending) && (!fifo_full || pop);

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      pending  <= '0;
      OVERFLOW <= 1'b0;
      for (int i = 0; i < N_TRIG; i++) holdoff[i] <= '0;
    end else begin
      pending  <= (pending & ~(push ? grant : '0)) | accept;
      OVERFLOW <= |dropv;
      for (int i = 0; i < N_TRIG; i++) begin
        if (accept[i])
          holdoff[i] <= HO_W'(HOLDOFF_MS);
        else if (ms_tick && in_hold[i])
          holdoff[i] <= holdoff[i] - 1'b1;
      end
    end
  end

  // ---- stage: hit queue
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  always_ff @(posedge SYSCLK) begin
    if (push) fifo_mem[wr_ptr] <= push_idx;
  end

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---- stage: message sequencer
`ifdef MIDI_RUNNING_STATUS_EN
  logic status_sent;

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET)
      status_sent <= 1'b0;
    else if (state == S_STATUS && uart_done)
      status_sent <= 1'b1;
  end

  assign skip_status = status_sent;
`else
  assign skip_status = 1'b0;
`endif

  assign pop = (state == S_IDLE) && !fifo_empty && !uart_busy;

  always_ff @(posedge SYSCLK) begin
    if (pop) idx_r <= fifo_mem[rd_ptr];
  end

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state   <= S_IDLE;
      start_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            start_r <= 1'b1;
            state   <= skip_status ? S_NOTE : S_STATUS;
          end
        end
        S_STATUS: if (uart_done) state <= S_NOTE;
        S_NOTE:   if (uart_done) state <= S_VEL;
        S_VEL:    if (uart_done) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // First byte comes from start_r; later bytes chain off done for back-to-back framing.
  assign uart_start = start_r || (uart_done && (state == S_STATUS || state == S_NOTE));

  always_comb begin
    tx_byte = STATUS_BYTE;
    case (state)
      S_STATUS: tx_byte = start_r ? STATUS_BYTE : note_of(idx_r);
      S_NOTE:   tx_byte = start_r ? note_of(idx_r) : VEL_BYTE;
      default:  tx_byte = STATUS_BYTE;
    endcase
  end

  midi_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk   (SYSCLK),
    .rst   (SYSRESET),
    .start (uart_start),
    .data  (tx_byte),
    .busy  (uart_busy),
    .done  (uart_done),
    .txd   (MIDI_TX)
  );

  assign BUSY = uart_busy || !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_piezo_midi_tx.sv
// Directed bench for piezo_midi_tx with scaled clocking (10-cycle bit, 20-cycle ms tick).
// Follows MIDI_RUNNING_STATUS_EN when the build defines it.
module tb_piezo_midi_tx;

  localparam int CLK_HZ     = 20_000;
  localparam int BAUD       = 2_000;
  localparam int HOLDOFF_MS = 4;
  localparam int DIV        = CLK_HZ / BAUD;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] trig;
  logic       midi_tx, busy, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_cnt = 0;
  int rxq[$];
  int rx_b;
  bit rs_sent;
  int ov0, lat, tmo;

  always #5 clk = ~clk;

  piezo_midi_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .N_TRIG     (6),
    .HOLDOFF_MS (HOLDOFF_MS),
    .FIFO_DEPTH (8),
    .MIDI_CH    (9),
    .VELOCITY   (100)
  ) dut (
    .SYSCLK   (clk),
    .SYSRESET (rst),
    .TRIG     (trig),
    .MIDI_TX  (midi_tx),
    .BUSY     (busy),
    .OVERFLOW (overflow)
  );

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  // Line receiver: samples mid-bit; bit 8 set in the pushed value marks a bad stop bit.
  initial begin
    forever begin
      @(negedge clk);
      if (midi_tx === 1'b0 && rst === 1'b0) begin
        rx_b = 0;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rx_b[i] = (midi_tx === 1'b1);
        end
        repeat (DIV) @(negedge clk);
        if (midi_tx !== 1'b1) rx_b = rx_b | 256;
        rxq.push_back(rx_b);
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic int lv(input logic b);
    return (b === 1'b1) ? 1 : ((b === 1'b0) ? 0 : 2);
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic get_byte(output int b);
    int t;
    t = 0;
    while (rxq.size() == 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (rxq.size() == 0) b = -1;
    else b = rxq.pop_front();
  endtask

  task automatic check_msg(input string tag, input int note);
    int b;
    if (!RS || !rs_sent) begin
      get_byte(b);
      check({tag, "_status"}, b, 8'h99);
    end
    get_byte(b);
    check({tag, "_note"}, b, note);
    get_byte(b);
    check({tag, "_vel"}, b, 100);
    rs_sent = 1'b1;
  endtask

  task automatic pulse(input logic [5:0] m, input int n);
    @(negedge clk);
    trig = m;
    tick(n);
    trig = '0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_busy_low"}, lv(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rs_sent = 1'b0;
    tick(5);
  endtask

  initial begin
    trig = '0;
    rst  = 1'b1;
    rs_sent = 1'b0;
    tick(3);
    check("rst_midi_tx", lv(midi_tx), 1);
    check("rst_busy", lv(busy), 0);
    check("rst_overflow", lv(overflow), 0);
    rst = 1'b0;
    tick(5);

    // 1: single hit, latency and message content
    @(negedge clk);
    trig = 6'h01;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && midi_tx === 1'b0) lat = k;
    end
    trig = '0;
    check("t1_latency", lat, 6);
    check_msg("t1", 8'h24);
    wait_idle("t1");
    tick(100);

    // 2: retrigger inside holdoff is ignored, after holdoff is accepted
    ov0 = ovf_cnt;
    pulse(6'h02, 3);
    tick(37);
    pulse(6'h02, 3);
    check_msg("t2a", 8'h26);
    wait_idle("t2a");
    tick(100);
    check("t2_single_msg", rxq.size(), 0);
    check("t2_no_overflow", ovf_cnt - ov0, 0);
    pulse(6'h02, 3);
    check_msg("t2b", 8'h26);
    wait_idle("t2b");
    tick(100);

    // 3: all six triggers in one cycle, lowest index first
    ov0 = ovf_cnt;
    pulse(6'h3F, 2);
    check_msg("t3_0", 36);
    check_msg("t3_1", 38);
    check_msg("t3_2", 42);
    check_msg("t3_3", 46);
    check_msg("t3_4", 49);
    check_msg("t3_5", 51);
    wait_idle("t3");
    check("t3_no_overflow", ovf_cnt - ov0, 0);
    tick(100);

    // 4: fill the queue, leave 3..5 pending, retrigger 3 and 4 after holdoff
    ov0 = ovf_cnt;
    pulse(6'h3F, 2);
    tick(88);
    pulse(6'h3F, 2);
    tick(81);
    pulse(6'h08, 2);
    pulse(6'h10, 2);
    tick(5);
    check("t4_overflow_count", ovf_cnt - ov0, 2);
    check_msg("t4_a0", 36);
    check_msg("t4_a1", 38);
    check_msg("t4_a2", 42);
    check_msg("t4_a3", 46);
    check_msg("t4_a4", 49);
    check_msg("t4_a5", 51);
    check_msg("t4_b0", 36);
    check_msg("t4_b1", 38);
    check_msg("t4_b2", 42);
    check_msg("t4_b3", 46);
    check_msg("t4_b4", 49);
    check_msg("t4_b5", 51);
    wait_idle("t4");
    check("t4_no_extra", rxq.size(), 0);
    check("t4_overflow_final", ovf_cnt - ov0, 2);
    tick(100);

    // 5: reset during data bit 0 of the NOTE byte (0x2A, bit 0 is low)
    pulse(6'h04, 2);
    tmo = 0;
    while (midi_tx !== 1'b0 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    check("t5_msg_started", lv(midi_tx), 0);
    tick(((!RS || !rs_sent) ? 100 : 0) + 15);
    check("t5_note_bit0", lv(midi_tx), 0);
    rst = 1'b1;
    #1;
    check("t5_tx_high_now", lv(midi_tx), 1);
    check("t5_busy_low_now", lv(busy), 0);
    tick(2);
    rst = 1'b0;
    rs_sent = 1'b0;
    tick(150);
    rxq.delete();
    pulse(6'h08, 2);
    check_msg("t5_clean", 8'h2E);
    wait_idle("t5");
    tick(100);

    // 6: status handling across consecutive messages and across reset
    do_reset();
    pulse(6'h04, 2);
    check_msg("t6a", 8'h2A);
    wait_idle("t6a");
    tick(100);
    pulse(6'h08, 2);
    check_msg("t6b", 8'h2E);
    wait_idle("t6b");
    tick(100);
    do_reset();
    pulse(6'h04, 2);
    check_msg("t6c", 8'h2A);
    wait_idle("t6c");
    tick(50);
    check("t6_no_extra", rxq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
